// File: rtl/ff_lab_pkg.sv
// Shared types and sizes for the D flip-flop lab exerciser.
package ff_lab_pkg;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_e;

    localparam int NSTEPS = 16;
    localparam int STEP_W = 4;
    localparam int ERR_W  = 5;

    typedef logic [STEP_W-1:0] step_t;
    typedef logic [ERR_W-1:0]  err_t;

endpackage

// File: rtl/ff_exerciser_phase_timer.sv
// Half-period down-counter for the generated flip-flop clock.
// k_o counts up from 0 within a phase; tc_o marks the last cycle of the phase.
module phase_timer #(
    parameter int DIV = 4,
    parameter int KW  = $clog2(DIV)
) (
    input  logic          clk_i,
    input  logic          clear_i,
    input  logic          load_i,
    output logic [KW-1:0] k_o,
    output logic          tc_o
);

    logic [KW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = KW'(DIV - 1);
        else if (cnt_q != '0)
            cnt_d = cnt_q - KW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (clear_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tc_o = (cnt_q == '0);
    assign k_o  = KW'(DIV - 1) - cnt_q;

endmodule

// File: rtl/ff_exerciser.sv
// Stimulus generator and response checker for the D flip-flop lab block:
// plays a 16-step data pattern against a generated clock and scores out/notout.
module ff_exerciser
    import ff_lab_pkg::*;
#(
    parameter int          DIV     = 4,
    parameter logic [15:0] PATTERN = 16'hA5C3
) (
    input  logic             clockpulse,
    input  logic             clear,
    input  logic             start,
    input  logic             out,
    input  logic             notout,
    output logic             dut_cp,
    output logic             dut_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] error_count,
    output logic [STEP_W-1:0] step,
    output logic [STEP_W-1:0] first_fail_step
);

    localparam int KW   = $clog2(DIV);
    localparam int HALF = DIV / 2;

    state_e        state_q, state_d;
    logic          cp_q, cp_d;
    logic          data_q, data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    err_t          err_q, err_d;
    step_t         step_q, step_d;
    step_t         ffs_q, ffs_d;
    logic          fail_a_q, fail_a_d;

    logic [KW-1:0] k;
    logic          tc;
    logic          timer_load;
    logic          start_ok;
    logic          exp_bit;
    logic          match;
    logic          check_a;
    logic          check_b;
    step_t         next_step;

    assign start_ok   = (state_q == IDLE || state_q == DONE) && start;
    assign timer_load = start_ok || ((state_q == LOW || state_q == HIGH) && tc);

    phase_timer #(.DIV(DIV), .KW(KW)) u_timer (
        .clk_i   (clockpulse),
        .clear_i (clear),
        .load_i  (timer_load),
        .k_o     (k),
        .tc_o    (tc)
    );

    assign exp_bit   = PATTERN[step_q];
    assign match     = (out == exp_bit) && (notout == ~exp_bit);
    assign check_a   = (state_q == HIGH) && (k == KW'(HALF - 1));
    assign check_b   = (state_q == HIGH) && tc;
    assign next_step = step_q + STEP_W'(1);

    // NOTE: clear is synchronous, so it lives inside the clocked block rather
    // than in the sensitivity list; every register returns to zero on that edge.
    always_ff @(posedge clockpulse) begin
        if (clear) begin
            state_q  <= IDLE;
            cp_q     <= 1'b0;
            data_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            step_q   <= '0;
            ffs_q    <= '0;
            fail_a_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cp_q     <= cp_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            step_q   <= step_d;
            ffs_q    <= ffs_d;
            fail_a_q <= fail_a_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (start) state_d = LOW;
            LOW:        if (tc)    state_d = HIGH;
            HIGH: begin
                if (tc)
                    state_d = (step_q == STEP_W'(NSTEPS - 1)) ? DONE : LOW;
            end
            default:    state_d = IDLE;
        endcase
    end

    // NOTE: every _d gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        cp_d     = (state_d == HIGH);
        busy_d   = (state_d == LOW) || (state_d == HIGH);
        done_d   = (state_d == DONE);
        data_d   = data_q;
        pass_d   = pass_q;
        err_d    = err_q;
        step_d   = step_q;
        ffs_d    = ffs_q;
        fail_a_d = fail_a_q;

        if (start_ok) begin
            data_d   = PATTERN[0];
            pass_d   = 1'b0;
            err_d    = '0;
            step_d   = '0;
            ffs_d    = '0;
            fail_a_d = 1'b0;
        end else if (state_q == HIGH) begin
            if (check_a && !match)
                fail_a_d = 1'b1;
            if (check_b) begin
                // One increment per step no matter which checks failed.
                if (fail_a_q || !match) begin
                    err_d = err_q + ERR_W'(1);
                    if (err_q == '0)
                        ffs_d = step_q;
                end
                fail_a_d = 1'b0;
                if (step_q == STEP_W'(NSTEPS - 1)) begin
                    data_d = 1'b0;
                    pass_d = (err_d == '0);
                end else begin
                    step_d = next_step;
                    data_d = PATTERN[next_step];
                end
            end else begin
                // Invert data for the second half of the high phase.
                data_d = (k >= KW'(HALF - 1)) ? ~exp_bit : exp_bit;
            end
        end
    end

    assign dut_cp          = cp_q;
    assign dut_data        = data_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign error_count     = err_q;
    assign step            = step_q;
    assign first_fail_step = ffs_q;

endmodule

// File: tb/tb_ff_exerciser.sv
// Self-checking bench for ff_exerciser: behavioural flip-flop models drive
// out/notout, and expected results are derived from the pattern bit by bit.
module tb_ff_exerciser;

    localparam int          DIV  = 4;
    localparam logic [15:0] PAT  = 16'hA5C3;
    localparam int          RUN  = 32 * DIV;

    logic       clockpulse = 1'b0;
    logic       clear;
    logic       start;
    logic       out_m;
    logic       notout_m;
    logic       dut_cp;
    logic       dut_data;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] error_count;
    logic [3:0] step;
    logic [3:0] first_fail_step;

    int          tests = 0;
    int          fails = 0;
    int          mode;
    logic [15:0] mask;
    int          cur_step;
    logic        dff_q;
    logic        lat_q;

    ff_exerciser #(.DIV(DIV), .PATTERN(PAT)) dut (
        .clockpulse      (clockpulse),
        .clear           (clear),
        .start           (start),
        .out             (out_m),
        .notout          (notout_m),
        .dut_cp          (dut_cp),
        .dut_data        (dut_data),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .error_count     (error_count),
        .step            (step),
        .first_fail_step (first_fail_step)
    );

    always #5 clockpulse = ~clockpulse;

    // Flip-flop under test: 0 ideal, 1 out stuck 0, 2 transparent latch,
    // 3 notout stuck 0, 4 ideal with out inverted on masked steps.
    always @(posedge dut_cp) dff_q <= dut_data;

    always_latch begin
        if (dut_cp) lat_q = dut_data;
    end

    always_comb begin
        out_m    = dff_q;
        notout_m = ~dff_q;
        case (mode)
            1: begin out_m = 1'b0; notout_m = 1'b1; end
            2: begin out_m = lat_q; notout_m = ~lat_q; end
            3: notout_m = 1'b0;
            4: if (mask[cur_step[3:0]]) out_m = ~dff_q;
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void expect_run(input int m, input logic [15:0] msk,
                                       output int err, output int ffs);
        logic [15:0] pat;
        logic        bad;
        pat = PAT;
        err = 0;
        ffs = 0;
        for (int i = 0; i < 16; i++) begin
            case (m)
                0:       bad = 1'b0;
                1:       bad = pat[i];
                2:       bad = 1'b1;
                3:       bad = ~pat[i];
                default: bad = msk[i];
            endcase
            if (bad) begin
                if (err == 0) ffs = i;
                err++;
            end
        end
    endfunction

    task automatic start_run(input string tag);
        start = 1'b1;
        @(posedge clockpulse);
        #1;
        start = 1'b0;
        cur_step = 0;
        check({tag, " start"},
              {15'd0, busy, done, pass, dut_cp, error_count, first_fail_step, step},
              {15'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 4'd0});
    endtask

    // Expected waveform of a run, cycle n after the start edge.
    task automatic run(input string tag, input int m, input logic [15:0] msk, input int start_at);
        logic [15:0] pat;
        int          wave_err;
        int          exp_err;
        int          exp_ffs;
        int          s;
        int          ph;
        logic        exp_cp;
        logic        exp_data;
        pat      = PAT;
        mode     = m;
        mask     = msk;
        wave_err = 0;
        start_run(tag);
        for (int n = 0; n < RUN; n++) begin
            if (n > 0) begin
                @(posedge clockpulse);
                #1;
            end
            s        = n / (2 * DIV);
            ph       = n % (2 * DIV);
            cur_step = s;
            exp_cp   = (ph >= DIV);
            exp_data = pat[s] ^ (ph >= DIV + DIV / 2);
            if (dut_cp !== exp_cp || dut_data !== exp_data || step !== 4'(s) ||
                busy !== 1'b1 || done !== 1'b0)
                wave_err++;
            start = (n == start_at);
        end
        check({tag, " waveform"}, wave_err, 0);
        @(posedge clockpulse);
        #1;
        start = 1'b0;
        expect_run(m, msk, exp_err, exp_ffs);
        check({tag, " done"}, {busy, done}, 2'b01);
        check({tag, " errors"}, error_count, exp_err);
        check({tag, " pass"}, pass, exp_err == 0);
        if (exp_err != 0)
            check({tag, " first_fail"}, first_fail_step, exp_ffs);
    endtask

    initial begin
        int          exp_err;
        int          exp_ffs;
        logic [15:0] rmask;
        logic [4:0]  held_err;

        clear    = 1'b1;
        start    = 1'b0;
        mode     = 0;
        mask     = '0;
        cur_step = 0;
        repeat (2) @(posedge clockpulse);
        #1;
        check("reset", {dut_cp, dut_data, busy, done, pass, error_count, step, first_fail_step}, '0);
        clear = 1'b0;
        repeat (3) @(posedge clockpulse);
        #1;
        check("idle no start", {busy, done}, 2'b00);

        run("ideal", 0, '0, -1);

        run("out0", 1, '0, -1);
        held_err = error_count;
        repeat (5) @(posedge clockpulse);
        #1;
        check("done hold", {done, pass, error_count}, {1'b1, 1'b0, held_err});

        // Restart from DONE with non-zero results pending; start check covers clearing.
        run("notout0", 3, '0, -1);
        run("latch", 2, '0, -1);
        run("midstart", 0, '0, 3 * 2 * DIV + 1);

        // Clear during the high phase of step 5.
        mode = 0;
        start_run("clear");
        for (int n = 1; n <= 5 * 2 * DIV + DIV + 1; n++) begin
            @(posedge clockpulse);
            #1;
        end
        check("clear at step", {dut_cp, step}, {1'b1, 4'd5});
        clear = 1'b1;
        @(posedge clockpulse);
        #1;
        clear = 1'b0;
        check("clear outputs", {dut_cp, dut_data, busy, done, pass, error_count, step, first_fail_step}, '0);
        repeat (4) @(posedge clockpulse);
        #1;
        check("clear idle", {busy, done, dut_cp}, 3'b000);
        run("after clear", 0, '0, -1);

        run("last step", 4, 16'h8000, -1);
        for (int r = 0; r < 4; r++) begin
            rmask = 16'($urandom);
            run($sformatf("rand%0d", r), 4, rmask, -1);
        end
        expect_run(4, 16'h0001, exp_err, exp_ffs);
        run("first step", 4, 16'h0001, -1);
        check("first step count", exp_err, {27'd0, error_count});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
